// File: rtl/risc_pkg.sv
// Shared types and encodings for the operand fetch stage and the stages after it.
package risc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP   = 3'd3,
    VALID = 3'd4
  } opf_state_t;

  // Shift codes applied to the Rm operand
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // ALU operation codes carried through this stage
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/operand_shifter.sv
// Single-bit barrel shift for the B operand; purely combinational so later
// stages can reuse it.
module operand_shifter
  import risc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] din_i,
  input  logic [1:0]    shift_i,
  output logic [DW-1:0] dout_o
);

  // Select the shifted form of the input
  always_comb begin
    dout_o = din_i;
    unique case (shift_i)
      SH_NONE: dout_o = din_i;
      SH_LSL:  dout_o = {din_i[DW-2:0], 1'b0};
      SH_LSR:  dout_o = {1'b0, din_i[DW-1:1]};
      SH_ASR:  dout_o = {din_i[DW-1], din_i[DW-1:1]};
      default: dout_o = din_i;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads Rn/Rm through the single synchronous register-file
// port, shifts Rm, and hands Ain/Bin/ALUop to the ALU with valid/ready.
// Optional same-cycle writeback forwarding: define OPFETCH_FWD_EN.
module operand_fetch
  import risc_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rn,
  input  logic [RW-1:0] in_rm,
  input  logic [1:0]    in_shift,
  input  logic [DW-1:0] in_imm,
  input  logic          in_asel,
  input  logic          in_bsel,
  input  logic [1:0]    in_aluop,
  output logic          rf_rd_en,
  output logic [RW-1:0] rf_rd_addr,
  input  logic [DW-1:0] rf_rd_data,
`ifdef OPFETCH_FWD_EN
  input  logic          wb_en,
  input  logic [RW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_ain,
  output logic [DW-1:0] out_bin,
  output logic [1:0]    out_aluop
);

  opf_state_t    state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [RW-1:0] rn_q, rn_d, rm_q, rm_d;
  logic [1:0]    shift_q, shift_d, aluop_q, aluop_d;
  logic          bsel_q, bsel_d;
  // Set when the read landing in the next capture slot is Rm (or no Rn read
  // is in flight), so RD_B/CAP know which operand the data belongs to.
  logic          pend_b_q, pend_b_d;
  logic [DW-1:0] cap_data, b_shifted;

`ifdef OPFETCH_FWD_EN
  logic [RW-1:0] cap_addr;

  // A writeback to the register being captured this cycle wins over the
  // stale register-file data.
  always_comb begin
    cap_addr = (state_q == CAP && pend_b_q) ? rm_q : rn_q;
    cap_data = (wb_en && wb_addr == cap_addr) ? wb_data : rf_rd_data;
  end
`else
  assign cap_data = rf_rd_data;
`endif

  operand_shifter #(.DW(DW)) u_shift (
    .din_i   (cap_data),
    .shift_i (shift_q),
    .dout_o  (b_shifted)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      shift_q  <= '0;
      aluop_q  <= '0;
      bsel_q   <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      shift_q  <= shift_d;
      aluop_q  <= aluop_d;
      bsel_q   <= bsel_d;
      pend_b_q <= pend_b_d;
    end
  end

  // Next state and operand capture
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    shift_d  = shift_q;
    aluop_d  = aluop_q;
    bsel_d   = bsel_q;
    pend_b_d = pend_b_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rn_d    = in_rn;
          rm_d    = in_rm;
          shift_d = in_shift;
          imm_d   = in_imm;
          aluop_d = in_aluop;
          bsel_d  = in_bsel;
          if (!in_asel) begin
            state_d = RD_A;
          end else begin
            a_d = '0;
            if (!in_bsel) begin
              pend_b_d = 1'b1;
              state_d  = RD_B;
            end else begin
              b_d     = in_imm;
              state_d = VALID;
            end
          end
        end
      end
      RD_A: begin
        pend_b_d = 1'b0;
        if (!bsel_q) begin
          state_d = RD_B;
        end else begin
          b_d     = imm_q;
          state_d = CAP;
        end
      end
      RD_B: begin
        if (!pend_b_q) a_d = cap_data;
        pend_b_d = 1'b1;
        state_d  = CAP;
      end
      CAP: begin
        if (pend_b_q) b_d = b_shifted;
        else          a_d = cap_data;
        state_d = VALID;
      end
      VALID: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and register-file strobes decoded from state
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == VALID);
    rf_rd_en   = (state_q == RD_A) || (state_q == RD_B);
    rf_rd_addr = '0;
    if (state_q == RD_A) rf_rd_addr = rn_q;
    if (state_q == RD_B) rf_rd_addr = rm_q;
  end

  assign out_ain   = a_q;
  assign out_bin   = b_q;
  assign out_aluop = aluop_q;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
Operand stage directly upstream of the ALU. It accepts a decoded instruction, reads up to two registers through the register file's single synchronous read port, and applies the barrel shift to the Rm operand. It then presents Ain/Bin/ALUop to the ALU stage under a valid/ready handshake. It replaces the controller-driven loada/loadb/asel/bsel sequencing with a self-contained FSM.

Parameters:
DW, 16, datapath width (Ain/Bin/immediate)
RW, 3, register address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  decoded instruction available
in_ready  out  1  stage can accept (IDLE only)
in_rn  in  RW  A-operand register
in_rm  in  RW  B-operand register
in_shift  in  2  shift code for Rm
in_imm  in  DW  sign-extended immediate
in_asel  in  1  1: Ain=0, no Rn read
in_bsel  in  1  1: Bin=in_imm, no Rm read, no shift
in_aluop  in  2  passed through to ALU
rf_rd_en  out  1  read strobe
rf_rd_addr  out  RW  read address
rf_rd_data  in  DW  read data, valid the cycle after rf_rd_en
out_valid  out  1  operands valid to ALU
out_ready  in  1  ALU stage accepts
out_ain  out  DW  A operand
out_bin  out  DW  B operand
out_aluop  out  2  latched ALUop

Behaviour:
- States: IDLE, RD_A, RD_B, CAP, VALID. Registers: A, B, latched rn/rm/shift/imm/aluop, flag pend_b (last outstanding read is Rm).
- Reset (async, any state): state=IDLE; A=B=0; out_valid=0, rf_rd_en=0, rf_rd_addr=0, out_aluop=0; in_ready=1 once state is IDLE.
- IDLE: in_ready=1. On in_valid: latch fields. asel=0 -> RD_A. asel=1,bsel=0 -> A=0, RD_B. asel=1,bsel=1 -> A=0, B=imm, VALID.
- RD_A: rf_rd_en=1, addr=rn. Next: if bsel=0 -> RD_B with pend_b=0; else B=imm, CAP with pend_b=0.
- RD_B: rf_rd_en=1, addr=rm. If entered from RD_A, capture rf_rd_data into A this cycle. Next: CAP with pend_b=1.
- CAP: rf_rd_en=0. Capture rf_rd_data into A if pend_b=0; otherwise into B after the shift (B = shift(rf_rd_data)). Next: VALID.
- Shift codes: 00 none, 01 LSL 1 (zero fill), 10 LSR 1 (zero fill), 11 ASR 1 (MSB replicated). Shift applies only to the Rm path, never to the immediate.
- VALID: out_valid=1; out_ain/out_bin/out_aluop held stable until out_ready. On out_ready -> IDLE. No new accept in VALID, so there is at least one bubble between instructions.
- Latency from accept edge to out_valid: 4 cycles (two reads), 3 cycles (one read), 1 cycle (no read).
- out_ain/out_bin mirror A/B. They are don't-care for the ALU but deterministic when out_valid=0.
- in_valid while not IDLE is ignored; the upstream must hold it.
- Reset mid-read discards the in-flight read. Any rf_rd_data returned after reset is ignored.

Optional Feature:
Macro OPFETCH_FWD_EN.
- Defined: adds ports wb_en (in 1), wb_addr (in RW), wb_data (in DW). In the capture cycle (RD_B for A, CAP for A or B), if wb_en && wb_addr equals the register being captured, wb_data replaces rf_rd_data. For B, the replacement happens before the shift. This resolves a same-cycle writeback hazard.
- Undefined: ports absent; capture always uses rf_rd_data.

Decomposition:
- Package risc_pkg holds:
  - state enum opf_state_t
  - shift codes SH_NONE/SH_LSL/SH_LSR/SH_ASR
  - ALUop codes ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_MVN=11
- One combinational sub-module: operand_shifter (in DW, shift 2 -> out DW). It is reused by later stages.

Test Plan:
- Reset asserted mid-RD_B with rn=1, rm=2 -> state=IDLE, out_valid=0, rf_rd_en=0, A=B=0 immediately without a clock edge; next instruction completes normally.
- R1=0x0007, R2=0x0003, rn=1, rm=2, shift=00, asel=bsel=0, aluop=00 -> rf_rd_addr 1 then 2 on consecutive cycles; out_valid 4 cycles after accept; ain=0x0007, bin=0x0003, aluop=00.
- rm=R3=0x8002, shift=11, asel=1, bsel=0 -> ain=0x0000, bin=0xC001, out_valid 3 cycles after accept; repeat with shift=10 -> bin=0x4001; shift=01 -> bin=0x0004.
- asel=1, bsel=1, imm=0xFFF8 -> no rf_rd_en; out_valid 1 cycle after accept; bin=0xFFF8, ain=0.
- out_ready held 0 for 5 cycles in VALID -> out_valid stays 1, operands stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- OPFETCH_FWD_EN: R2 reads 0x0003, wb_en=1, wb_addr=2, wb_data=0x0010 in CAP, shift=01 -> bin=0x0020; with wb_addr=5 -> bin=0x0006.
